pi_fifo_bridge: RTL



---
 rtl/pi_fifo_bridge_pkg.sv | 56 +++++
 rtl/pi_fifo_bridge_if.sv | 13 +
 rtl/pi_fifo_bridge_fifo_sc.sv | 77 +++++++
 rtl/pi_fifo_bridge.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pi_fifo_bridge_pkg.sv
// pi_fifo_bridge_pkg
//   Types and constants shared by the PI FIFO bridge, its bus interface
//   and its FIFO sub-module:
//     PiMap / PiBus  - chip-enable map and PI bus bundle from the SPI front end
//     PiSel          - access latched when the PI transfer is decoded
//     FIFO_*         - register offsets inside the FIFO window (addr[15:8])
//     ST_*, CTRL_*   - STATUS / CTRL bit positions
package pi_fifo_bridge_pkg;

  typedef struct packed {
    logic ce_rom;
    logic ce_sram;
    logic ce_fifo;   // 64K window at 0x1810000
    logic ce_sys;
  } PiMap;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  dato;   // write data from the MCU
    logic        oe;
    logic        we;
    logic        act;    // transfer strobe, asynchronous to clk
    PiMap        map;
  } PiBus;

  typedef struct packed {
    logic       oe;
    logic       we;
    logic [7:0] off;
  } PiSel;

  localparam logic [31:0] FIFO_BASE  = 32'h0181_0000;
  localparam logic [7:0]  EMPTY_BYTE = 8'hFF;

  localparam logic [7:0] FIFO_DATA = 8'h00;
  localparam logic [7:0] FIFO_STAT = 8'h01;
  localparam logic [7:0] FIFO_CTRL = 8'h02;
  localparam logic [7:0] FIFO_CNT  = 8'h03;

  localparam int ST_C2M_NE    = 0;
  localparam int ST_C2M_FULL  = 1;
  localparam int ST_M2C_EMPTY = 2;
  localparam int ST_M2C_FULL  = 3;
  localparam int ST_OVF       = 6;
  localparam int ST_UDF       = 7;

  localparam int CTRL_FLUSH_M2C = 0;
  localparam int CTRL_FLUSH_C2M = 1;
  localparam int CTRL_CLR_ERR   = 7;

  // Register offset within the FIFO window.
  function automatic logic [7:0] fifo_offset(input logic [31:0] addr);
    return addr[15:8];
  endfunction

endpackage

// File: rtl/pi_fifo_bridge_if.sv
// pi_fifo_bridge_if
//   PI-side bus of the FIFO bridge.
//     pi      - PI bus bundle driven by the SPI front end (master)
//     pi_dato - registered read data returned by the bridge (slave)
interface pi_fifo_bridge_if;
  import pi_fifo_bridge_pkg::*;

  PiBus       pi;
  logic [7:0] pi_dato;

  modport master (output pi, input pi_dato);
  modport slave  (input pi, output pi_dato);
endinterface

// File: rtl/pi_fifo_bridge_fifo_sc.sv
// fifo_sc
//   Single-clock first-word-fall-through byte FIFO.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset
//     push, din - enqueue din
//     pop       - dequeue the head
//     flush     - empty the FIFO (beats a same-cycle push)
//     dout      - head byte, 0xFF when empty
//     count     - occupancy, 0..DEPTH
//     full, empty
//     err_ovf   - pulse: push rejected because full
//     err_udf   - pulse: pop rejected because empty
module fifo_sc
  import pi_fifo_bridge_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          err_ovf,
  output logic          err_udf
);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign count = count_reg;

  // A pop frees a slot in the same cycle, so push-on-full with a pop is legal.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign err_ovf = push & ~do_push;
  assign err_udf = pop & empty;

  // Head is read combinationally so the next byte falls through the cycle
  // after a pop.
  assign dout = empty ? EMPTY_BYTE : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pi_fifo_bridge.sv
// pi_fifo_bridge
//   Byte mailbox between the MCU-side PI bus and the CPU side, two FIFOs:
//   m2c (PI writes, CPU reads) and c2m (CPU writes, PI reads).
//   Ports:
//     clk, rst   - clock, synchronous active-high reset
//     pi_bus     - PI bus (slave modport): pi bundle in, registered pi_dato out
//     cpu_wr     - one-clk pulse, push cpu_dati into c2m
//     cpu_dati   - CPU write byte
//     cpu_rd     - one-clk pulse, pop m2c
//     cpu_dato   - m2c head (0xFF when empty)
//     cpu_rx_rdy - m2c not empty
//     cpu_tx_rdy - c2m not full
//     irq        - m2c not empty or an error flag set
module pi_fifo_bridge
  import pi_fifo_bridge_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  pi_fifo_bridge_if.slave    pi_bus,
  input  logic               cpu_wr,
  input  logic [7:0]         cpu_dati,
  input  logic               cpu_rd,
  output logic [7:0]         cpu_dato,
  output logic               cpu_rx_rdy,
  output logic               cpu_tx_rdy,
  output logic               irq
);

  localparam int M2C = 0;
  localparam int C2M = 1;

  // act synchroniser and edge detection
  logic       act_s1_reg;
  logic       act_s2_reg;
  logic       act_hist_reg;
  logic [1:0] settle_reg;
  logic       arm_reg;
  logic       rise;
  logic       fall;

  // decode / execute
  PiSel       sel_reg;
  logic [7:0] wdata_reg;
  logic       dec_stb_reg;
  logic       rd_pend_reg;
  logic [7:0] pi_dato_reg;
  logic       ovf_reg;
  logic       udf_reg;
  logic       sel_rd;
  logic       sel_wr;
  logic       ctrl_wr;
  logic       err_clr;
  logic [7:0] status;
  logic [7:0] rd_mux;

  // FIFO pair, index M2C / C2M
  logic [1:0]  f_push;
  logic [1:0]  f_pop;
  logic [1:0]  f_flush;
  logic [1:0]  f_full;
  logic [1:0]  f_empty;
  logic [1:0]  f_ovf;
  logic [1:0]  f_udf;
  logic [7:0]  f_din   [2];
  logic [7:0]  f_dout  [2];
  logic [AW:0] f_cnt   [2];

  // After reset the synchroniser restarts from 0, so an act that was already
  // high would look like a fresh rise. Edges are only honoured once act has
  // been seen low through a settled synchroniser; this drops any transfer
  // caught in progress by reset.
  assign rise = act_s2_reg & ~act_hist_reg & arm_reg;
  assign fall = ~act_s2_reg & act_hist_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_s1_reg   <= 1'b0;
      act_s2_reg   <= 1'b0;
      act_hist_reg <= 1'b0;
      settle_reg   <= 2'd0;
      arm_reg      <= 1'b0;
      sel_reg      <= '0;
      wdata_reg    <= 8'h00;
      dec_stb_reg  <= 1'b0;
      rd_pend_reg  <= 1'b0;
    end else begin
      act_s1_reg   <= pi_bus.pi.act;
      act_s2_reg   <= act_s1_reg;
      act_hist_reg <= act_s2_reg;
      if (!settle_reg[1]) settle_reg <= settle_reg + 2'd1;
      if (settle_reg[1] && !act_s2_reg) arm_reg <= 1'b1;

      dec_stb_reg <= 1'b0;
      if (rise && pi_bus.pi.map.ce_fifo) begin
        sel_reg.oe  <= pi_bus.pi.oe;
        sel_reg.we  <= pi_bus.pi.we;
        sel_reg.off <= fifo_offset(pi_bus.pi.addr);
        if (pi_bus.pi.we) wdata_reg <= pi_bus.pi.dato;
        dec_stb_reg <= 1'b1;
        // A DATA read pops c2m only when act falls, after pi_dato is taken.
        rd_pend_reg <= pi_bus.pi.oe && (fifo_offset(pi_bus.pi.addr) == FIFO_DATA);
      end else if (fall) begin
        rd_pend_reg <= 1'b0;
      end
    end
  end

  // Execute stage: one clk after decode.
  assign sel_rd  = sel_reg.oe;
  assign sel_wr  = sel_reg.we & ~sel_reg.oe;
  assign ctrl_wr = dec_stb_reg & sel_wr & (sel_reg.off == FIFO_CTRL);
  assign err_clr = ctrl_wr & wdata_reg[CTRL_CLR_ERR];

  assign f_push[M2C]  = dec_stb_reg & sel_wr & (sel_reg.off == FIFO_DATA);
  assign f_din[M2C]   = wdata_reg;
  assign f_pop[M2C]   = cpu_rd;
  assign f_flush[M2C] = ctrl_wr & wdata_reg[CTRL_FLUSH_M2C];

  assign f_push[C2M]  = cpu_wr;
  assign f_din[C2M]   = cpu_dati;
  assign f_pop[C2M]   = fall & rd_pend_reg;
  assign f_flush[C2M] = ctrl_wr & wdata_reg[CTRL_FLUSH_C2M];

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    fifo_sc #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (f_push[gi]),
      .din     (f_din[gi]),
      .pop     (f_pop[gi]),
      .flush   (f_flush[gi]),
      .dout    (f_dout[gi]),
      .count   (f_cnt[gi]),
      .full    (f_full[gi]),
      .empty   (f_empty[gi]),
      .err_ovf (f_ovf[gi]),
      .err_udf (f_udf[gi])
    );
  end

  always_comb begin
    status               = 8'h00;
    status[ST_C2M_NE]    = ~f_empty[C2M];
    status[ST_C2M_FULL]  = f_full[C2M];
    status[ST_M2C_EMPTY] = f_empty[M2C];
    status[ST_M2C_FULL]  = f_full[M2C];
    status[ST_OVF]       = ovf_reg;
    status[ST_UDF]       = udf_reg;
  end

  always_comb begin
    rd_mux = EMPTY_BYTE;
    case (sel_reg.off)
      FIFO_DATA: rd_mux = f_dout[C2M];
      FIFO_STAT: rd_mux = status;
      FIFO_CTRL: rd_mux = 8'h00;
      FIFO_CNT:  rd_mux = 8'(f_cnt[C2M]);
      default:   rd_mux = EMPTY_BYTE;
    endcase
  end

  // pi_dato is loaded once per read and then holds until the next decode,
  // so the c2m pop on fall does not disturb the byte being shifted out.
  // A same-cycle new error wins over a clear (OR applied after the mask).
  always_ff @(posedge clk) begin
    if (rst) begin
      pi_dato_reg <= EMPTY_BYTE;
      ovf_reg     <= 1'b0;
      udf_reg     <= 1'b0;
    end else begin
      if (dec_stb_reg && sel_rd) pi_dato_reg <= rd_mux;
      ovf_reg <= (ovf_reg & ~err_clr) | (|f_ovf);
      udf_reg <= (udf_reg & ~err_clr) | (|f_udf);
    end
  end

  assign pi_bus.pi_dato = pi_dato_reg;
  assign cpu_dato       = f_dout[M2C];
  assign cpu_rx_rdy     = ~f_empty[M2C];
  assign cpu_tx_rdy     = ~f_full[C2M];
  assign irq            = ~f_empty[M2C] | ovf_reg | udf_reg;

  // Address bits outside the offset byte and the other chip enables are
  // decoded upstream; the m2c count is not exposed.
  logic unused_bits;
  assign unused_bits = ^{pi_bus.pi.addr[31:16], pi_bus.pi.addr[7:0],
                         pi_bus.pi.map.ce_rom, pi_bus.pi.map.ce_sram,
                         pi_bus.pi.map.ce_sys, f_cnt[M2C]};

endmodule
